// File: rtl/udp_tx_framer.sv
// udp_tx_framer: UDP transmit layer. Latches the user header, requests an IPv4
// transmission, then streams the 8-byte big-endian UDP header followed by the payload.
module udp_tx_framer #(
    parameter logic [7:0]  UDP_PROTOCOL = 8'd17,
    parameter logic [15:0] MAX_PAYLOAD  = 16'd65507
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        udp_tx_start,
    input  logic [31:0] udp_tx_dst_ip_addr,
    input  logic [15:0] udp_tx_dst_port,
    input  logic [15:0] udp_tx_src_port,
    input  logic [15:0] udp_tx_data_length,
    input  logic [15:0] udp_tx_checksum,
    input  logic [7:0]  udp_tx_data_in,
    input  logic        udp_tx_data_in_valid,
    input  logic        udp_tx_data_in_last,
    output logic        udp_tx_data_in_ready,
    output logic [1:0]  udp_tx_result,
    output logic        ip_tx_start,
    output logic [7:0]  ip_tx_protocol,
    output logic [15:0] ip_tx_data_length,
    output logic [31:0] ip_tx_dst_ip_addr,
    output logic [7:0]  ip_tx_data_out,
    output logic        ip_tx_data_out_valid,
    output logic        ip_tx_data_out_last,
    input  logic        ip_tx_data_out_ready,
    input  logic [1:0]  ip_tx_result
);
    typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_DATA, DONE} state_t;
    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_SENDING = 2'd1,
        RES_ERR     = 2'd2,
        RES_SENT    = 2'd3
    } result_t;

    state_t      state_q, state_d;
    result_t     result_q, result_d;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic        err_q, err_d;
    logic        start_q, start_d;
    logic        latch, abort, cnt_last;
    logic [15:0] src_q, dst_q, len_q, cksum_q, udp_len;
    logic [7:0]  proto_q;
    logic [15:0] iplen_q;
    logic [31:0] ipdst_q;
    logic [7:0]  hdr_byte;

    assign udp_len           = len_q + 16'd8;
    assign udp_tx_result     = result_q;
    assign ip_tx_start       = start_q;
    assign ip_tx_protocol    = proto_q;
    assign ip_tx_data_length = iplen_q;
    assign ip_tx_dst_ip_addr = ipdst_q;

    always_comb begin
        case (hdr_cnt_q)
            3'd0:    hdr_byte = src_q[15:8];
            3'd1:    hdr_byte = src_q[7:0];
            3'd2:    hdr_byte = dst_q[15:8];
            3'd3:    hdr_byte = dst_q[7:0];
            3'd4:    hdr_byte = udp_len[15:8];
            3'd5:    hdr_byte = udp_len[7:0];
            3'd6:    hdr_byte = cksum_q[15:8];
            default: hdr_byte = cksum_q[7:0];
        endcase
    end

    always_comb begin
        state_d              = state_q;
        result_d             = result_q;
        hdr_cnt_d            = hdr_cnt_q;
        pay_cnt_d            = pay_cnt_q;
        err_d                = err_q;
        start_d              = 1'b0;
        latch                = 1'b0;
        ip_tx_data_out       = '0;
        ip_tx_data_out_valid = 1'b0;
        ip_tx_data_out_last  = 1'b0;
        udp_tx_data_in_ready = 1'b0;
        abort                = (state_q != IDLE) && (ip_tx_result == RES_ERR);
        cnt_last             = (pay_cnt_q == len_q - 16'd1);

        unique case (state_q)
            IDLE: begin
                if (udp_tx_start) begin
                    if ((udp_tx_data_length > MAX_PAYLOAD) || (ip_tx_result == RES_SENDING)) begin
                        result_d = RES_ERR;
                    end else begin
                        latch     = 1'b1;
                        start_d   = 1'b1;
                        result_d  = RES_SENDING;
                        hdr_cnt_d = '0;
                        pay_cnt_d = '0;
                        err_d     = 1'b0;
                        state_d   = SEND_HDR;
                    end
                end
            end
            SEND_HDR: begin
                ip_tx_data_out       = hdr_byte;
                ip_tx_data_out_valid = 1'b1;
                ip_tx_data_out_last  = (hdr_cnt_q == 3'd7) && (len_q == '0);
                if (ip_tx_data_out_ready) begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    if (hdr_cnt_q == 3'd7)
                        state_d = (len_q == '0) ? DONE : SEND_DATA;
                end
            end
            SEND_DATA: begin
                ip_tx_data_out       = udp_tx_data_in;
                ip_tx_data_out_valid = udp_tx_data_in_valid;
                ip_tx_data_out_last  = cnt_last || udp_tx_data_in_last;
                udp_tx_data_in_ready = ip_tx_data_out_ready;
                if (udp_tx_data_in_valid && ip_tx_data_out_ready) begin
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    // Either end condition closes the datagram; they only agree on a well-formed frame.
                    if (cnt_last || udp_tx_data_in_last) begin
                        state_d = DONE;
                        if (cnt_last != udp_tx_data_in_last)
                            err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                result_d = err_q ? RES_ERR : RES_SENT;
                err_d    = 1'b0;
                state_d  = IDLE;
            end
        endcase

        if (abort) begin
            ip_tx_data_out_valid = 1'b0;
            ip_tx_data_out_last  = 1'b0;
            udp_tx_data_in_ready = 1'b0;
            result_d             = RES_ERR;
            err_d                = 1'b0;
            state_d              = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= RES_NONE;
            hdr_cnt_q <= '0;
            pay_cnt_q <= '0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cksum_q   <= '0;
            proto_q   <= '0;
            iplen_q   <= '0;
            ipdst_q   <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            hdr_cnt_q <= hdr_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            err_q     <= err_d;
            start_q   <= start_d;
            if (latch) begin
                src_q   <= udp_tx_src_port;
                dst_q   <= udp_tx_dst_port;
                len_q   <= udp_tx_data_length;
                cksum_q <= udp_tx_checksum;
                proto_q <= UDP_PROTOCOL;
                iplen_q <= udp_tx_data_length + 16'd8;
                ipdst_q <= udp_tx_dst_ip_addr;
            end
        end
    end
endmodule

// File: tb/tb_udp_tx_framer.sv
// Bench for udp_tx_framer: table-driven frames, randomized frames against a
// datagram-level reference model, and hand sequences for reject/abort/reset.
module tb_udp_tx_framer;
    logic        clk = 1'b0;
    logic        reset;
    logic        udp_tx_start;
    logic [31:0] udp_tx_dst_ip_addr;
    logic [15:0] udp_tx_dst_port, udp_tx_src_port, udp_tx_data_length, udp_tx_checksum;
    logic [7:0]  udp_tx_data_in;
    logic        udp_tx_data_in_valid, udp_tx_data_in_last, udp_tx_data_in_ready;
    logic [1:0]  udp_tx_result;
    logic        ip_tx_start;
    logic [7:0]  ip_tx_protocol;
    logic [15:0] ip_tx_data_length;
    logic [31:0] ip_tx_dst_ip_addr;
    logic [7:0]  ip_tx_data_out;
    logic        ip_tx_data_out_valid, ip_tx_data_out_last, ip_tx_data_out_ready;
    logic [1:0]  ip_tx_result;

    always #5 clk = ~clk;

    udp_tx_framer #(.UDP_PROTOCOL(8'd17), .MAX_PAYLOAD(16'd65507)) dut (
        .clk(clk), .reset(reset), .udp_tx_start(udp_tx_start),
        .udp_tx_dst_ip_addr(udp_tx_dst_ip_addr), .udp_tx_dst_port(udp_tx_dst_port),
        .udp_tx_src_port(udp_tx_src_port), .udp_tx_data_length(udp_tx_data_length),
        .udp_tx_checksum(udp_tx_checksum), .udp_tx_data_in(udp_tx_data_in),
        .udp_tx_data_in_valid(udp_tx_data_in_valid), .udp_tx_data_in_last(udp_tx_data_in_last),
        .udp_tx_data_in_ready(udp_tx_data_in_ready), .udp_tx_result(udp_tx_result),
        .ip_tx_start(ip_tx_start), .ip_tx_protocol(ip_tx_protocol),
        .ip_tx_data_length(ip_tx_data_length), .ip_tx_dst_ip_addr(ip_tx_dst_ip_addr),
        .ip_tx_data_out(ip_tx_data_out), .ip_tx_data_out_valid(ip_tx_data_out_valid),
        .ip_tx_data_out_last(ip_tx_data_out_last), .ip_tx_data_out_ready(ip_tx_data_out_ready),
        .ip_tx_result(ip_tx_result)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Monitor: records every transferred byte and counts handshakes.
    logic [8:0] obuf [0:4095];
    int wr = 0, nstart = 0, nacc = 0, rdy_err = 0;
    int active = 0, base = 0, exp_total = 0;

    always @(negedge clk) begin
        if (ip_tx_start) nstart <= nstart + 1;
        if (ip_tx_data_out_valid && ip_tx_data_out_ready) begin
            obuf[wr % 4096] <= {ip_tx_data_out_last, ip_tx_data_out};
            wr <= wr + 1;
        end
        if (udp_tx_data_in_valid && udp_tx_data_in_ready) nacc <= nacc + 1;
        // Source ready follows the IP side only while payload bytes are still owed.
        if (active != 0) begin
            if (udp_tx_data_in_ready !== ((((wr - base) >= 8) && ((wr - base) < exp_total))
                                          ? ip_tx_data_out_ready : 1'b0))
                rdy_err <= rdy_err + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input string tag, input logic [31:0] ip, input logic [15:0] src,
                             input logic [15:0] dst, input logic [15:0] len, input logic [15:0] ck,
                             input int nsrc, input int rmode, input int vgap, input bit rnd,
                             input int exp_n, input int exp_res);
        logic [7:0] pay [0:15];
        logic [7:0] exp_b [0:31];
        int n, total, idx, cyc, b0, a0, s0, r0, res_exp, ulen, got;
        bit err;
        for (int i = 0; i < 16; i++) pay[i] = rnd ? 8'($urandom) : 8'(170 + 17 * i);
        n       = (int'(len) < nsrc) ? int'(len) : nsrc;
        err     = (len != 16'd0) && (nsrc != int'(len));
        total   = 8 + n;
        res_exp = err ? 2 : 3;
        ulen    = int'(len) + 8;
        exp_b[0] = src[15:8];        exp_b[1] = src[7:0];
        exp_b[2] = dst[15:8];        exp_b[3] = dst[7:0];
        exp_b[4] = 8'(ulen / 256);   exp_b[5] = 8'(ulen % 256);
        exp_b[6] = ck[15:8];         exp_b[7] = ck[7:0];
        for (int i = 0; i < n; i++) exp_b[8 + i] = pay[i];

        @(posedge clk); #1;
        b0 = wr; a0 = nacc; s0 = nstart; r0 = rdy_err;
        base = wr; exp_total = total; active = 1;
        udp_tx_dst_ip_addr = ip; udp_tx_src_port = src; udp_tx_dst_port = dst;
        udp_tx_data_length = len; udp_tx_checksum = ck; udp_tx_start = 1'b1;
        idx = 0; cyc = 0;
        while (1) begin
            udp_tx_data_in_valid = (idx < nsrc) && (vgap == 0 || $urandom_range(0, 2) != 0);
            udp_tx_data_in       = pay[idx % 16];
            udp_tx_data_in_last  = (idx == nsrc - 1);
            case (rmode)
                0:       ip_tx_data_out_ready = 1'b1;
                1:       ip_tx_data_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: ip_tx_data_out_ready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk); #1;
            if (udp_tx_data_in_valid && udp_tx_data_in_ready) idx++;
            if ((cyc >= 2 && udp_tx_result != 2'd1) || cyc > 400) break;
            @(posedge clk); #1;
            udp_tx_start = 1'b0;
            cyc++;
        end
        udp_tx_data_in_valid = 1'b0;
        udp_tx_data_in_last  = 1'b0;
        ip_tx_data_out_ready = 1'b1;
        active = 0;
        got = wr - b0;

        check({tag, " timeout"}, 32'(cyc > 400), 32'd0);
        check({tag, " start_pulses"}, 32'(nstart - s0), 32'd1);
        check({tag, " ip_len"}, 32'(ip_tx_data_length), 32'(ulen));
        check({tag, " protocol"}, 32'(ip_tx_protocol), 32'd17);
        check({tag, " dst_ip"}, ip_tx_dst_ip_addr, ip);
        check({tag, " nbytes"}, 32'(got), 32'(total));
        for (int i = 0; i < total && i < got; i++)
            check($sformatf("%s byte%0d", tag, i), 32'(obuf[(b0 + i) % 4096]),
                  32'({(i == total - 1), exp_b[i]}));
        check({tag, " src_accepted"}, 32'(nacc - a0), 32'(n));
        check({tag, " in_ready"}, 32'(rdy_err - r0), 32'd0);
        check({tag, " result"}, 32'(udp_tx_result), 32'(res_exp));
        if (exp_n >= 0)   check({tag, " tbl_nbytes"}, 32'(got), 32'(exp_n));
        if (exp_res >= 0) check({tag, " tbl_result"}, 32'(udp_tx_result), 32'(exp_res));
    endtask

    task automatic pulse_start(input logic [15:0] len);
        @(posedge clk); #1;
        udp_tx_dst_ip_addr = 32'hC0A80A0A; udp_tx_src_port = 16'h1234;
        udp_tx_dst_port = 16'h5678; udp_tx_data_length = len; udp_tx_checksum = 16'h0;
        udp_tx_start = 1'b1;
        @(posedge clk); #1;
        udp_tx_start = 1'b0;
    endtask

    task automatic nominal(input string tag);
        run_frame(tag, 32'hC0A80A0A, 16'h1234, 16'h5678, 16'd4, 16'h0, 4, 0, 0, 0, 12, 3);
    endtask

    typedef struct {
        logic [15:0] len;
        logic [15:0] ck;
        int nsrc;
        int rmode;
        int exp_n;
        int exp_res;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, b0;
        tbl[0] = '{16'd4, 16'h0000, 4, 0, 12, 3};  // nominal
        tbl[1] = '{16'd4, 16'h0000, 4, 1, 12, 3};  // backpressure 1,0,0,1
        tbl[2] = '{16'd0, 16'h0000, 0, 0,  8, 3};  // zero-length payload
        tbl[3] = '{16'd4, 16'h0000, 2, 0, 10, 2};  // early source last
        tbl[4] = '{16'd2, 16'h0000, 3, 0, 10, 2};  // source longer than length
        tbl[5] = '{16'd1, 16'hBEEF, 1, 1,  9, 3};  // checksum pass-through

        reset = 1'b1; udp_tx_start = 1'b0; udp_tx_dst_ip_addr = '0; udp_tx_dst_port = '0;
        udp_tx_src_port = '0; udp_tx_data_length = '0; udp_tx_checksum = '0;
        udp_tx_data_in = '0; udp_tx_data_in_valid = 1'b0; udp_tx_data_in_last = 1'b0;
        ip_tx_data_out_ready = 1'b1; ip_tx_result = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset outputs", 32'({ip_tx_data_out_valid, ip_tx_data_out_last, ip_tx_data_out,
                                    udp_tx_data_in_ready, ip_tx_start, udp_tx_result}), 32'd0);
        check("reset ip fields", 32'({ip_tx_protocol, ip_tx_data_length}), 32'd0);
        check("reset dst_ip", ip_tx_dst_ip_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_frame($sformatf("row%0d", i), 32'hC0A80A0A, 16'h1234, 16'h5678, tbl[i].len,
                      tbl[i].ck, tbl[i].nsrc, tbl[i].rmode, 0, 0, tbl[i].exp_n, tbl[i].exp_res);

        // Oversized length is rejected without an IP request.
        nominal("pre_reject");
        s0 = nstart;
        pulse_start(16'd65508);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reject_len result", 32'(udp_tx_result), 32'd2);
        check("reject_len start", 32'(nstart - s0), 32'd0);

        // IP block busy.
        nominal("pre_busy");
        ip_tx_result = 2'd1;
        s0 = nstart;
        pulse_start(16'd4);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reject_busy result", 32'(udp_tx_result), 32'd2);
        check("reject_busy start", 32'(nstart - s0), 32'd0);
        ip_tx_result = 2'd0;

        // Largest legal length is accepted; the IP block aborts after header byte 3.
        s0 = nstart; b0 = wr;
        pulse_start(16'd65507);
        for (int c = 0; c < 50 && (wr - b0) < 4; c++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        ip_tx_result = 2'd2;
        @(negedge clk); #1;
        check("abort valid", 32'(ip_tx_data_out_valid), 32'd0);
        check("abort ip_len", 32'(ip_tx_data_length), 32'd65515);
        check("abort start", 32'(nstart - s0), 32'd1);
        check("abort hdr", 32'({obuf[b0 % 4096][7:0], obuf[(b0 + 1) % 4096][7:0],
                                obuf[(b0 + 2) % 4096][7:0], obuf[(b0 + 3) % 4096][7:0]}),
              32'h12345678);
        @(posedge clk); #1;
        ip_tx_result = 2'd0;
        @(negedge clk); #1;
        check("abort result", 32'(udp_tx_result), 32'd2);
        check("abort nbytes", 32'(wr - b0), 32'd4);
        nominal("post_abort");

        // Reset in the middle of the payload.
        b0 = wr;
        udp_tx_data_in = 8'h5A; udp_tx_data_in_valid = 1'b1; udp_tx_data_in_last = 1'b0;
        pulse_start(16'd4);
        for (int c = 0; c < 50 && (wr - b0) < 10; c++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        reset = 1'b1; udp_tx_data_in_valid = 1'b0;
        @(posedge clk); #1;
        udp_tx_data_in_valid = 1'b1;
        @(negedge clk); #1;
        check("midreset outputs", 32'({ip_tx_data_out_valid, ip_tx_data_out_last, ip_tx_data_out,
                                       udp_tx_data_in_ready, ip_tx_start, udp_tx_result}), 32'd0);
        check("midreset ip fields", 32'({ip_tx_protocol, ip_tx_data_length}), 32'd0);
        check("midreset dst_ip", ip_tx_dst_ip_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        udp_tx_data_in_valid = 1'b0;
        @(negedge clk); #1;
        check("midreset nbytes", 32'(wr - b0), 32'd10);
        nominal("post_reset");

        // Randomized frames with random gaps and backpressure.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] len;
            int nsrc;
            len  = 16'($urandom_range(0, 6));
            nsrc = ($urandom_range(0, 9) < 7) ? int'(len) : $urandom_range(1, 6);
            run_frame($sformatf("rand%0d", i), $urandom, 16'($urandom), 16'($urandom), len,
                      16'($urandom), nsrc, 2, 1, 1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/udp_tx_framer.md
Name: udp_tx_framer

Overview:
- Transmit-side UDP layer between the user UDP TX interface (header + AXI byte stream) and the IPv4 TX block.
- Latches the UDP header on start and requests an IPv4 transmission with protocol 17 and length = payload + 8.
- Emits the 8-byte UDP header (src port, dst port, length, checksum; big-endian), then forwards payload bytes with valid/ready flow control.
- Reports progress on a 2-bit result code using the UDPTX_RESULT_* encoding.

Parameters:
- UDP_PROTOCOL, 8'd17, value driven on ip_tx_protocol.
- MAX_PAYLOAD, 16'd65507, largest accepted udp_tx_data_length; above this the request is rejected.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- udp_tx_start  in  1  request; sampled only in IDLE.
- udp_tx_dst_ip_addr  in  32  destination IP.
- udp_tx_dst_port  in  16  destination port.
- udp_tx_src_port  in  16  source port.
- udp_tx_data_length  in  16  payload bytes, excluding the UDP header.
- udp_tx_checksum  in  16  UDP checksum, passed through; 0 means not used.
- udp_tx_data_in  in  8  payload byte.
- udp_tx_data_in_valid  in  1  payload byte valid.
- udp_tx_data_in_last  in  1  final payload byte.
- udp_tx_data_in_ready  out  1  payload byte accepted this cycle when high with valid.
- udp_tx_result  out  2  NONE=0, SENDING=1, ERR=2, SENT=3.
- ip_tx_start  out  1  one-cycle request to the IPv4 TX block.
- ip_tx_protocol  out  8  constant UDP_PROTOCOL.
- ip_tx_data_length  out  16  latched data_length + 8.
- ip_tx_dst_ip_addr  out  32  latched destination IP.
- ip_tx_data_out  out  8  byte to the IPv4 TX block.
- ip_tx_data_out_valid  out  1  byte valid.
- ip_tx_data_out_last  out  1  final byte of the datagram.
- ip_tx_data_out_ready  in  1  IPv4 TX accepts the byte.
- ip_tx_result  in  2  IPTX_RESULT_* from the IPv4 TX block.

Behaviour:
- Reset (one clk edge with reset=1): state=IDLE, all outputs 0, udp_tx_result=NONE, counters 0. Reset mid-packet aborts immediately; no further bytes are emitted.
- A byte transfers on ip_tx_data_out only in a cycle where valid=1 and ready=1.

States:
- IDLE, entered on udp_tx_start=1:
  - udp_tx_data_length > MAX_PAYLOAD, or ip_tx_result=SENDING (IP busy): set result=ERR, stay in IDLE.
  - Otherwise: latch all header inputs, pulse ip_tx_start for exactly 1 cycle, set result=SENDING, go to SEND_HDR.
  - ip_tx_start rises on the clock edge after start is sampled.
  - ip_tx_protocol, ip_tx_data_length and ip_tx_dst_ip_addr are held from the latch until the next accepted start.
- SEND_HDR:
  - hdr_cnt runs 0..7; ip_tx_data_out_valid=1; udp_tx_data_in_ready=0.
  - Byte order: src_port[15:8], src_port[7:0], dst_port[15:8], dst_port[7:0], len[15:8], len[7:0], cksum[15:8], cksum[7:0], where len = data_length + 8.
  - hdr_cnt advances only on a transfer.
  - After byte 7 transfers: go to SEND_DATA, or to DONE when data_length=0. For data_length=0, byte 7 carries last=1.
- SEND_DATA (combinational pass-through, zero latency):
  - ip_tx_data_out = udp_tx_data_in; valid = udp_tx_data_in_valid; udp_tx_data_in_ready = ip_tx_data_out_ready.
  - 16-bit pay_cnt increments on each transfer.
  - ip_tx_data_out_last = 1 when pay_cnt = data_length - 1.
  - Source last arriving early (last=1 with pay_cnt < data_length-1): the byte is forwarded with last=1, err_flag is set, go to DONE.
  - Count reached without source last: the stream is truncated at data_length bytes, err_flag is set, go to DONE. Extra source bytes are not accepted.
- DONE (1 cycle): result=ERR if err_flag, else SENT. Clear err_flag, return to IDLE. The result holds until the next accepted start or reset.
- Abort: in any non-IDLE state, ip_tx_result=ERR causes result=ERR, valid=0 and return to IDLE on the next edge.
- udp_tx_start outside IDLE is ignored; no queuing.

Test Plan:
- Nominal datagram:
  - Stimulus: start with ip 0xC0A80A0A, src 0x1234, dst 0x5678, len 4, cksum 0, payload AA BB CC DD (last on DD), ready=1.
  - Required response: one ip_tx_start pulse, ip_tx_data_length=12, protocol=17; output 12 34 56 78 00 0C 00 00 AA BB CC DD with last only on DD; result SENDING, then SENT.
- Backpressure:
  - Stimulus: same frame as the nominal case with ip_tx_data_out_ready toggled 1,0,0,1,...
  - Required response: identical byte sequence with no drops or duplicates; udp_tx_data_in_ready mirrors ready during payload.
- Zero-length payload:
  - Stimulus: len 0.
  - Required response: 8 header bytes, length field 0x0008, last on byte 8, result SENT, udp_tx_data_in_ready never asserted.
- Length mismatch:
  - Stimulus: len 4 with source last on the 2nd byte.
  - Required response: 10 bytes out, last on the 10th, result ERR.
  - Stimulus: len 2 with a 3-byte source.
  - Required response: 10 bytes out, 3rd source byte not accepted, result ERR.
- Rejects:
  - Stimulus: start with len 65508.
  - Required response: result ERR, no ip_tx_start.
  - Stimulus: start while ip_tx_result=SENDING.
  - Required response: result ERR, no ip_tx_start.
- Abort and reset:
  - Stimulus: ip_tx_result=ERR after header byte 3.
  - Required response: valid drops, result ERR, block in IDLE.
  - Stimulus: reset asserted mid-payload.
  - Required response: all outputs 0 and result NONE on the next edge; a following start sends a clean frame.
